// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// memory-wait freeze with timeout, halt freeze, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       idRegRs_IN,
    input  logic             idRsUsed_IN,
    input  logic [2:0]       idRegRt_IN,
    input  logic             idRtUsed_IN,
    input  logic             exMemRead_IN,
    input  logic             exWriteEn_IN,
    input  logic [2:0]       exWriteRegSel_IN,
    input  logic             memReq_IN,
    input  logic             memDone_IN,
    input  logic             brTaken_IN,
    input  logic             haltMW_IN,
    output logic             stallPC_OUT,
    output logic             stallFD_OUT,
    output logic             stallDX_OUT,
    output logic             stallXM_OUT,
    output logic             stallMW_OUT,
    output logic             flushFD_OUT,
    output logic             bubbleDX_OUT,
    output logic             halted_OUT,
    output logic             memErr_OUT,
    output logic [1:0]       state_OUT,
    output logic [CNT_W-1:0] stallCount_OUT
);

    localparam int TW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             halted_q, halted_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic freeze;
    logic luse;

    always_comb begin
        freeze = ((state_q == ST_RUN) && memReq_IN && !memDone_IN) ||
                 ((state_q == ST_MEMWAIT) && !memDone_IN) ||
                 (state_q == ST_HALTED);
        luse   = exMemRead_IN && exWriteEn_IN &&
                 ((idRsUsed_IN && (idRegRs_IN == exWriteRegSel_IN)) ||
                  (idRtUsed_IN && (idRegRt_IN == exWriteRegSel_IN)));
    end

    // Freeze outranks branch, branch outranks load-use (the stalled instruction is wrong-path).
    always_comb begin
        stallPC_OUT  = 1'b0;
        stallFD_OUT  = 1'b0;
        stallDX_OUT  = 1'b0;
        stallXM_OUT  = 1'b0;
        stallMW_OUT  = 1'b0;
        flushFD_OUT  = 1'b0;
        bubbleDX_OUT = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stallPC_OUT = 1'b1;
                stallFD_OUT = 1'b1;
                stallDX_OUT = 1'b1;
                stallXM_OUT = 1'b1;
                stallMW_OUT = 1'b1;
            end else if (brTaken_IN) begin
                flushFD_OUT  = 1'b1;
                bubbleDX_OUT = 1'b1;
            end else if (luse) begin
                stallPC_OUT  = 1'b1;
                stallFD_OUT  = 1'b1;
                bubbleDX_OUT = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            ST_RUN: begin
                if (memReq_IN && !memDone_IN) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = TW'(1);
                end else if (haltMW_IN) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MEMWAIT: begin
                if (memDone_IN) begin
                    state_d    = haltMW_IN ? ST_HALTED : ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TMO) begin
                    state_d   = ST_HALTED;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            default: state_d = ST_HALTED;
        endcase
        halted_d    = (state_d == ST_HALTED);
        stall_cnt_d = stall_cnt_q;
        if (stallPC_OUT && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted_OUT     = halted_q;
    assign memErr_OUT     = mem_err_q;
    assign state_OUT      = state_q;
    assign stallCount_OUT = stall_cnt_q;

endmodule
